// File: rtl/yarvi_me_buf_if.sv
// rtl/yarvi_me_buf_if.sv - ex-side request/return and memory-side bus bundle for yarvi_me_buf (optional YARVI_ME_MISALIGN_TRAP_EN adds misalign report)
interface yarvi_me_buf_if #(
    parameter int XLEN = 64,
    parameter int VLEN = 64
);
    logic                valid;
    logic                writeenable;
    logic [VLEN-1:0]     address;
    logic [XLEN-1:0]     writedata;
    logic [1:0]          sizelg2;
    logic [4:0]          readtag;
    logic                readsignextend;
    logic                me_ready;
    logic                me_readdatavalid;
    logic [4:0]          me_readdatatag;
    logic [XLEN-1:0]     me_readdata;
    logic                mem_req;
    logic                mem_we;
    logic [VLEN-1:0]     mem_addr;
    logic [XLEN-1:0]     mem_wdata;
    logic [XLEN/8-1:0]   mem_wstrb;
    logic                mem_ack;
    logic                mem_rvalid;
    logic [XLEN-1:0]     mem_rdata;
`ifdef YARVI_ME_MISALIGN_TRAP_EN
    logic                me_misaligned;
    logic [4:0]          me_misaligned_tag;
`endif

    // Load/store unit view
    modport slave (
        input  valid, writeenable, address, writedata, sizelg2, readtag, readsignextend,
        output me_ready, me_readdatavalid, me_readdatatag, me_readdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ack, mem_rvalid, mem_rdata
`ifdef YARVI_ME_MISALIGN_TRAP_EN
        , output me_misaligned, me_misaligned_tag
`endif
    );

    // Execute stage plus backing memory view
    modport master (
        output valid, writeenable, address, writedata, sizelg2, readtag, readsignextend,
        input  me_ready, me_readdatavalid, me_readdatatag, me_readdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ack, mem_rvalid, mem_rdata
`ifdef YARVI_ME_MISALIGN_TRAP_EN
        , input me_misaligned, me_misaligned_tag
`endif
    );
endinterface

// File: rtl/yarvi_me_buf.sv
// rtl/yarvi_me_buf.sv - buffered in-order load/store unit with outstanding-load tracker (optional YARVI_ME_MISALIGN_TRAP_EN)
module yarvi_me_buf #(
    parameter int XLEN     = 64,
    parameter int VLEN     = 64,
    parameter int DEPTH    = 4,
    parameter int MAXREADS = 4
) (
    input  logic             clock,
    input  logic             reset,
    yarvi_me_buf_if.slave    bus
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int FPW  = $clog2(DEPTH);
    localparam int CW   = FPW + 1;
    localparam int RPW  = (MAXREADS > 1) ? $clog2(MAXREADS) : 1;
    localparam int RCW  = $clog2(MAXREADS) + 1;

    typedef struct packed {
        logic            we;
        logic [VLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [1:0]      size;
        logic [4:0]      tag;
        logic            sext;
    } req_t;

    typedef struct packed {
        logic [4:0]      tag;
        logic [1:0]      size;
        logic            sext;
        logic [OFFW-1:0] off;
    } rd_t;

    req_t            fifo [DEPTH];
    logic [FPW-1:0]  wp, rp;
    logic [CW-1:0]   count;
    rd_t             trk [MAXREADS];
    logic [RPW-1:0]  twp, trp;
    logic [RCW-1:0]  rcount;

    req_t            in_entry, head;
    rd_t             in_rd, th;
    logic [1:0]      in_size;
    logic [OFFW-1:0] lowmask, off;
    logic            misaligned, accept, push, pop, tpush, tpop;
    logic [NB-1:0]   strb_base;
    logic [XLEN-1:0] shifted, extended;
    logic            sign_bit;

    assign bus.me_ready = (count != CW'(DEPTH));
    assign accept       = bus.valid && bus.me_ready;
    assign head         = fifo[rp];
    assign th           = trk[trp];
    assign bus.mem_req  = (count != '0) && (head.we || rcount != RCW'(MAXREADS));
    assign pop          = bus.mem_req && bus.mem_ack;
    assign tpush        = pop && !head.we;
    assign tpop         = bus.mem_rvalid && (rcount != '0);
    assign off          = head.addr[OFFW-1:0];

`ifdef YARVI_ME_MISALIGN_TRAP_EN
    assign push = accept && !misaligned;
`else
    assign push = accept;
`endif

    // Clamp oversize accesses and align the enqueued address to the access size
    always_comb begin
        in_size = bus.sizelg2;
        if (int'(bus.sizelg2) > OFFW)
            in_size = 2'(OFFW);
        lowmask    = OFFW'((1 << in_size) - 1);
        misaligned = (bus.address[OFFW-1:0] & lowmask) != '0;
        in_entry.we    = bus.writeenable;
        in_entry.addr  = bus.address & ~{{(VLEN-OFFW){1'b0}}, lowmask};
        in_entry.wdata = bus.writedata;
        in_entry.size  = in_size;
        in_entry.tag   = bus.readtag;
        in_entry.sext  = bus.readsignextend;
    end

    // Memory-side formatting of the FIFO head: word address, strobes, replicated data
    always_comb begin
        bus.mem_we   = head.we;
        bus.mem_addr = {head.addr[VLEN-1:OFFW], {OFFW{1'b0}}};
        for (int i = 0; i < NB; i++)
            strb_base[i] = (i < (1 << head.size));
        bus.mem_wstrb = strb_base << off;
        case (head.size)
            2'd0:    bus.mem_wdata = {(XLEN/8){head.wdata[7:0]}};
            2'd1:    bus.mem_wdata = {(XLEN/16){head.wdata[15:0]}};
            2'd2:    bus.mem_wdata = {(XLEN/32){head.wdata[31:0]}};
            default: bus.mem_wdata = head.wdata;
        endcase
        in_rd.tag  = head.tag;
        in_rd.size = head.size;
        in_rd.sext = head.sext;
        in_rd.off  = off;
    end

    // Lane extraction and sign/zero extension of returning read data
    always_comb begin
        shifted = bus.mem_rdata >> {th.off, 3'b000};
        case (th.size)
            2'd0:    sign_bit = shifted[7];
            2'd1:    sign_bit = shifted[15];
            2'd2:    sign_bit = shifted[31];
            default: sign_bit = shifted[XLEN-1];
        endcase
        for (int i = 0; i < XLEN; i++)
            extended[i] = (i < (8 << th.size)) ? shifted[i] : (th.sext & sign_bit);
    end

    // Queue storage; contents are only meaningful under the counters, so no reset
    always_ff @(posedge clock) begin
        if (push)
            fifo[wp] <= in_entry;
        if (tpush)
            trk[twp] <= in_rd;
    end

    // Pointers, occupancy counters and registered load return
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
            twp <= '0;
            trp <= '0;
            rcount <= '0;
            bus.me_readdatavalid <= 1'b0;
            bus.me_readdatatag <= '0;
            bus.me_readdata <= '0;
        end else begin
            if (push)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (tpush)
                twp <= (int'(twp) == MAXREADS - 1) ? '0 : twp + 1'b1;
            if (tpop)
                trp <= (int'(trp) == MAXREADS - 1) ? '0 : trp + 1'b1;
            case ({tpush, tpop})
                2'b10:   rcount <= rcount + 1'b1;
                2'b01:   rcount <= rcount - 1'b1;
                default: rcount <= rcount;
            endcase
            bus.me_readdatavalid <= tpop;
            if (tpop) begin
                bus.me_readdatatag <= th.tag;
                bus.me_readdata <= extended;
            end
        end
    end

`ifdef YARVI_ME_MISALIGN_TRAP_EN
    // One-cycle report of a dropped misaligned request
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.me_misaligned <= 1'b0;
            bus.me_misaligned_tag <= '0;
        end else begin
            bus.me_misaligned <= accept && misaligned;
            bus.me_misaligned_tag <= (accept && misaligned && !bus.writeenable) ? bus.readtag : 5'd0;
        end
    end
`endif
endmodule

// File: tb/tb_yarvi_me_buf.sv
// tb/tb_yarvi_me_buf.sv - directed self-checking bench for yarvi_me_buf
module tb_yarvi_me_buf;
    logic clock;
    logic reset;
    int   checks;
    int   failures;

    yarvi_me_buf_if #(.XLEN(64), .VLEN(64)) bus ();

    yarvi_me_buf #(.XLEN(64), .VLEN(64), .DEPTH(4), .MAXREADS(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic we, input logic [63:0] addr, input logic [63:0] data,
                             input logic [1:0] size, input logic [4:0] tag, input logic sext);
        bus.valid = 1'b1;
        bus.writeenable = we;
        bus.address = addr;
        bus.writedata = data;
        bus.sizelg2 = size;
        bus.readtag = tag;
        bus.readsignextend = sext;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        bus.valid = 1'b0;
        bus.writeenable = 1'b0;
        bus.address = '0;
        bus.writedata = '0;
        bus.sizelg2 = '0;
        bus.readtag = '0;
        bus.readsignextend = 1'b0;
        bus.mem_ack = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = '0;
        step();
        step();
        check("rst_ready", 64'(bus.me_ready), 64'd1);
        check("rst_req", 64'(bus.mem_req), 64'd0);
        check("rst_rdv", 64'(bus.me_readdatavalid), 64'd0);
        check("rst_tag", 64'(bus.me_readdatatag), 64'd0);
        check("rst_data", bus.me_readdata, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_ready", 64'(bus.me_ready), 64'd1);
            check("idle_req", 64'(bus.mem_req), 64'd0);
            check("idle_rdv", 64'(bus.me_readdatavalid), 64'd0);
        end

        // Byte store formatting
        drive_req(1'b1, 64'h1003, 64'hAB, 2'd0, 5'd0, 1'b0);
        step();
        bus.valid = 1'b0;
        check("st_req", 64'(bus.mem_req), 64'd1);
        check("st_we", 64'(bus.mem_we), 64'd1);
        check("st_addr", bus.mem_addr, 64'h1000);
        check("st_strb", 64'(bus.mem_wstrb), 64'h08);
        check("st_wdata", bus.mem_wdata, 64'hABABABABABABABAB);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        check("st_popped", 64'(bus.mem_req), 64'd0);

        // Halfword store at odd address is silently aligned down
        drive_req(1'b1, 64'h1007, 64'h1234, 2'd1, 5'd0, 1'b0);
        step();
        bus.valid = 1'b0;
        check("sth_addr", bus.mem_addr, 64'h1000);
        check("sth_strb", 64'(bus.mem_wstrb), 64'hC0);
        check("sth_wdata", bus.mem_wdata, 64'h1234123412341234);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;

        // Signed and unsigned halfword loads from lane 6
        for (int k = 0; k < 2; k++) begin
            drive_req(1'b0, 64'h2006, 64'h0, 2'd1, (k == 0) ? 5'd7 : 5'd8, (k == 0));
            step();
            bus.valid = 1'b0;
            check("ld_req", 64'(bus.mem_req), 64'd1);
            check("ld_we", 64'(bus.mem_we), 64'd0);
            check("ld_addr", bus.mem_addr, 64'h2000);
            bus.mem_ack = 1'b1;
            step();
            bus.mem_ack = 1'b0;
            check("ld_no_early_rdv", 64'(bus.me_readdatavalid), 64'd0);
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata = 64'h8001_0000_0000_0000;
            step();
            bus.mem_rvalid = 1'b0;
            check("ld_rdv", 64'(bus.me_readdatavalid), 64'd1);
            check("ld_tag", 64'(bus.me_readdatatag), (k == 0) ? 64'd7 : 64'd8);
            check("ld_data", bus.me_readdata, (k == 0) ? 64'hFFFF_FFFF_FFFF_8001 : 64'h0000_0000_0000_8001);
            step();
            check("ld_rdv_pulse", 64'(bus.me_readdatavalid), 64'd0);
        end

        // Fill the FIFO with the memory stalled
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b1, 64'h100 + 64'(8 * i), 64'(i), 2'd3, 5'd0, 1'b0);
            step();
        end
        check("full_ready", 64'(bus.me_ready), 64'd0);
        drive_req(1'b1, 64'h120, 64'h4, 2'd3, 5'd0, 1'b0);
        step();
        check("full_held", 64'(bus.me_ready), 64'd0);
        check("full_head_stable", bus.mem_addr, 64'h100);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        check("full_after_ack", 64'(bus.me_ready), 64'd1);
        step();
        bus.valid = 1'b0;
        check("full_again", 64'(bus.me_ready), 64'd0);
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_addr", bus.mem_addr, 64'h108 + 64'(8 * i));
            step();
        end
        bus.mem_ack = 1'b0;
        check("drain_empty", 64'(bus.mem_req), 64'd0);
        check("drain_ready", 64'(bus.me_ready), 64'd1);

        // Outstanding-load limit of two, then in-order return
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b0, 64'h3000 + 64'(8 * i), 64'h0, 2'd3, 5'(i + 1), 1'b0);
            step();
        end
        bus.valid = 1'b0;
        check("maxrd_blocked", 64'(bus.mem_req), 64'd0);
        check("maxrd_ready", 64'(bus.me_ready), 64'd1);
        bus.mem_rvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.mem_rdata = 64'h1111_0000_0000_0000 * 64'(i + 1);
            step();
            check("ret_rdv", 64'(bus.me_readdatavalid), 64'd1);
            check("ret_tag", 64'(bus.me_readdatatag), 64'(i + 1));
            check("ret_data", bus.me_readdata, 64'h1111_0000_0000_0000 * 64'(i + 1));
        end
        bus.mem_rvalid = 1'b0;
        bus.mem_ack = 1'b0;
        step();
        check("ret_done", 64'(bus.me_readdatavalid), 64'd0);
        check("ret_idle", 64'(bus.mem_req), 64'd0);

        // Reset with two queued and one outstanding
        drive_req(1'b0, 64'h4000, 64'h0, 2'd3, 5'd9, 1'b0);
        step();
        drive_req(1'b1, 64'h5000, 64'h1, 2'd3, 5'd0, 1'b0);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        drive_req(1'b1, 64'h5008, 64'h2, 2'd3, 5'd0, 1'b0);
        step();
        bus.valid = 1'b0;
        check("pre_rst_req", 64'(bus.mem_req), 64'd1);
        check("pre_rst_head", bus.mem_addr, 64'h5000);
        reset = 1'b1;
        step();
        check("mid_rst_ready", 64'(bus.me_ready), 64'd1);
        check("mid_rst_req", 64'(bus.mem_req), 64'd0);
        check("mid_rst_rdv", 64'(bus.me_readdatavalid), 64'd0);
        check("mid_rst_tag", 64'(bus.me_readdatatag), 64'd0);
        check("mid_rst_data", bus.me_readdata, 64'd0);
        reset = 1'b0;
        step();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 64'hDEAD_BEEF_0000_0001;
        step();
        bus.mem_rvalid = 1'b0;
        check("stale_rvalid", 64'(bus.me_readdatavalid), 64'd0);
        step();
        check("post_rst_req", 64'(bus.mem_req), 64'd0);
        check("post_rst_ready", 64'(bus.me_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
